// File: rtl/uart_tx_unit.sv
// 8N1 UART serializer: loads {stop, data, start} on a start request and shifts it
// out LSB first, one bit every BAUD clock cycles.
module uart_tx_unit #(
  parameter int BAUD = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data,
  input  logic       start,
  output logic       ready,
  output logic       tx
);

  // state    | meaning
  // ST_IDLE  | line high, ready=1, waiting for start
  // ST_TX    | frame on the line, ready=0, start ignored
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_TX   = 1'b1;

  localparam int            CW      = (BAUD > 2) ? $clog2(BAUD) : 1;
  localparam logic [CW-1:0] BAUD_TC = CW'(BAUD - 1);
  localparam logic [3:0]    LAST_BIT = 4'd9;

  logic [0:0]    state_q, state_d;
  logic [9:0]    shift_q, shift_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [CW-1:0] baud_cnt_q, baud_cnt_d;

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    baud_cnt_d = baud_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_TX;
          shift_d    = {1'b1, data, 1'b0};
          bit_cnt_d  = 4'd0;
          baud_cnt_d = '0;
        end
      end
      default: begin
        if (baud_cnt_q == BAUD_TC) begin
          baud_cnt_d = '0;
          // After the stop bit the register is refilled with ones so the line stays idle-high.
          if (bit_cnt_q == LAST_BIT) begin
            state_d   = ST_IDLE;
            shift_d   = '1;
            bit_cnt_d = 4'd0;
          end else begin
            shift_d   = {1'b1, shift_q[9:1]};
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end else begin
          baud_cnt_d = baud_cnt_q + CW'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      shift_q    <= '1;
      bit_cnt_q  <= 4'd0;
      baud_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      baud_cnt_q <= baud_cnt_d;
    end
  end

  assign ready = (state_q == ST_IDLE);
  assign tx    = shift_q[0];

endmodule

// File: tb/tb_uart_tx_unit.sv
// Directed self-checking bench for uart_tx_unit: a BAUD=4 instance for frame details
// and a default-BAUD instance decoded by a simple mid-bit sampling receiver.
module tb_uart_tx_unit;

  logic       clk;
  logic       rst;
  logic [7:0] data, data2;
  logic       start, start2;
  logic       ready, tx, ready2, tx2;

  int n_tests = 0;
  int n_fail  = 0;

  uart_tx_unit #(.BAUD(4)) dut (
    .clk(clk), .rst(rst), .data(data), .start(start), .ready(ready), .tx(tx)
  );

  uart_tx_unit dut_def (
    .clk(clk), .rst(rst), .data(data2), .start(start2), .ready(ready2), .tx(tx2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Entered just after the edge that accepted start; seq[i] is the i-th bit on the line.
  task automatic check_frame(input string tag, input logic [9:0] seq);
    for (int b = 0; b < 10; b++) begin
      for (int c = 0; c < 4; c++) begin
        check({tag, "_tx"}, {31'd0, tx}, {31'd0, seq[b]});
        check({tag, "_busy"}, {31'd0, ready}, 32'd0);
        step();
      end
    end
    check({tag, "_ready_back"}, {31'd0, ready}, 32'd1);
    check({tag, "_tx_idle"}, {31'd0, tx}, 32'd1);
  endtask

  initial begin
    logic [7:0] rx_byte;
    bit         seen;

    rst = 1'b0; data = 8'h00; start = 1'b0; data2 = 8'h00; start2 = 1'b0;

    for (int i = 0; i < 5; i++) begin
      step();
      check("rst_tx", {31'd0, tx}, 32'd1);
      check("rst_ready", {31'd0, ready}, 32'd1);
      check("rst_tx2", {31'd0, tx2}, 32'd1);
    end
    rst = 1'b1;
    for (int i = 0; i < 100; i++) begin
      step();
      check("idle_tx", {31'd0, tx}, 32'd1);
      check("idle_ready", {31'd0, ready}, 32'd1);
    end

    // Single frame 0x55
    data = 8'h55; start = 1'b1;
    step();
    start = 1'b0;
    check_frame("f55", 10'b1010101010);

    // Data latched at start: 0xA3 on the line even though data changes to 0xFF
    step();
    data = 8'hA3; start = 1'b1;
    step();
    start = 1'b0; data = 8'hFF;
    check_frame("fA3", 10'b1101000110);

    // Continuous start with 0x00: ready high for one cycle, frames 41 cycles apart
    step();
    data = 8'h00; start = 1'b1;
    step();
    check_frame("cont1", 10'b1000000000);
    step();
    check("cont_gap_ready", {31'd0, ready}, 32'd0);
    check("cont_restart_tx", {31'd0, tx}, 32'd0);
    check_frame("cont2", 10'b1000000000);
    start = 1'b0;
    step();
    check("cont_stop_ready", {31'd0, ready}, 32'd1);
    check("cont_stop_tx", {31'd0, tx}, 32'd1);

    // Reset asserted during data bit 3 (frame bit 4) of a 0x00 frame
    data = 8'h00; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 17; i++) step();
    check("mid_pre_tx", {31'd0, tx}, 32'd0);
    check("mid_pre_ready", {31'd0, ready}, 32'd0);
    #2 rst = 1'b0;
    #1;
    check("mid_async_tx", {31'd0, tx}, 32'd1);
    check("mid_async_ready", {31'd0, ready}, 32'd1);
    step();
    step();
    rst = 1'b1;
    step();
    check("post_rst_tx", {31'd0, tx}, 32'd1);
    check("post_rst_ready", {31'd0, ready}, 32'd1);
    data = 8'h3C; start = 1'b1;
    step();
    start = 1'b0;
    check_frame("f3C", 10'b1001111000);

    // Default BAUD=434: 'A' decoded by mid-bit sampling receiver
    data2 = 8'h41; start2 = 1'b1;
    step();
    start2 = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      if (tx2 == 1'b0) seen = 1'b1;
      else step();
    end
    check("def_start_seen", {31'd0, seen}, 32'd1);
    rx_byte = 8'h00;
    for (int off = 0; off <= 4340; off++) begin
      if (off % 434 == 217) begin
        if (off / 434 == 0) check("def_start_bit", {31'd0, tx2}, 32'd0);
        else if (off / 434 == 9) check("def_stop_bit", {31'd0, tx2}, 32'd1);
        else rx_byte[off / 434 - 1] = tx2;
      end
      if (off == 433) check("def_bit0_end", {31'd0, tx2}, 32'd0);
      if (off == 434) check("def_bit1_begin", {31'd0, tx2}, 32'd1);
      if (off == 4339) check("def_ready_late", {31'd0, ready2}, 32'd0);
      if (off == 4340) check("def_ready_back", {31'd0, ready2}, 32'd1);
      if (off < 4340) step();
    end
    check("def_rx_byte", {24'd0, rx_byte}, 32'h41);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_unit.md
Name: uart_tx_unit

Overview:
- 8N1 UART serializer: accepts one byte on a start request and shifts it out on a single serial line at a parameterised bit period.
- Sits between a command/data sequencer FSM and the board TX pin.
- Exposes a ready flag so the sequencer can wait between frames.
- Default timing: 115200 baud from a 50 MHz clock.

Parameters:
- BAUD, 434: bit period in clk cycles; legal range is 2 or more. Standard values: 434=115200, 868=57600, 5208=9600, 166667=300 at 50 MHz.

Ports:
- clk, input, 1: system clock; all logic is rising-edge.
- rst, input, 1: asynchronous, active-low reset.
- data, input, 8: byte to transmit; sampled only at frame start.
- start, input, 1: transmit request; level-sensitive, sampled on clk.
- ready, output, 1: 1 = idle and able to accept a frame; 0 = frame in progress.
- tx, output, 1: serial output; idles high.

Behaviour:
- Reset: clk is the clock; rst is asynchronous, active-low.
  - While rst=0: tx=1, ready=1, shift register = all ones, bit counter = 0, baud counter = 0.
  - Reset asserted mid-frame aborts the frame immediately; no partial stop bit is sent.
- Frame format, LSB first: start bit 0, then data[0]..data[7], then stop bit 1. Total 10 bits.
- Two states:
  - IDLE: ready=1, tx=1.
  - TRANSMIT: ready=0.
- IDLE -> TRANSMIT: on the rising edge where start=1.
  - That same edge loads the 10-bit shift register {1, data, 0}.
  - tx=0 and ready=0 become visible after that edge, i.e. 1-cycle latency from start sampled to start-bit on the line.
  - data is captured at this edge; changes to data or start during the frame are ignored.
- Baud counter runs 0..BAUD-1 while in TRANSMIT.
  - On terminal count it wraps to 0, the shift register shifts right with 1 filled in, tx takes the new LSB, and the bit counter increments.
  - Every bit, including the stop bit, lasts exactly BAUD cycles.
- tx is registered (glitch-free) and driven from shift-register bit 0.
- TRANSMIT -> IDLE: at the end of the 10th bit period, i.e. 10*BAUD cycles after the start bit began.
  - ready returns to 1 and tx stays 1.
- Back-to-back frames with start held continuously high:
  - After a frame completes, ready=1 for exactly one cycle.
  - The next frame starts on the following edge.
  - Frame spacing is 10*BAUD+1 cycles, so the stop bit is effectively 1 cycle longer.
- start=1 while ready=0: no effect, no queuing.
- Baud counter width: ceil(log2(BAUD)) bits; it must hold 166666 (18 bits) without overflow.
- No parity, no flow control, no break generation.

Test Plan (BAUD=4 unless stated):
- Reset values: hold rst=0 for 5 cycles -> tx=1 and ready=1 throughout; release and leave start=0 for 100 cycles -> tx stays 1, ready stays 1.
- Single frame: data=0x55, start pulsed for 1 cycle -> next cycle tx=0 and ready=0; tx sequence per 4-cycle bit = 0,1,0,1,0,1,0,1,0,1; ready=1 exactly 40 cycles after it fell.
- Data latch: start with data=0xA3, change data to 0xFF on the next cycle -> line carries 0,1,1,0,0,0,1,0,1,1 (0xA3 LSB first plus framing).
- Continuous start, data=0x00: start held high -> consecutive frames 41 cycles apart; ready high for exactly 1 cycle between frames; start=1 mid-frame does not restart the frame.
- Reset mid-frame: assert rst=0 during data bit 3 -> tx=1 and ready=1 asynchronously; after release the next start sends a complete, correct frame.
- Default BAUD=434, data=0x41 ('A') -> each bit 434 cycles; frame 4340 cycles; receiver model decodes 0x41 at 115200 baud with a 50 MHz clock.
